// File: rtl/fetch_pkg.sv
// Shared types for the fetch->decode queue: the empty-queue NOP and the stored entry layout.
package fetch_pkg;
  localparam int FQ_INSTR_W = 32;
  localparam int FQ_PC_W    = 32;

  // MOV r0,r0 with condition AL
  localparam logic [FQ_INSTR_W-1:0] NOP_INSTR = 32'hE1A00000;

  typedef struct packed {
    logic [FQ_INSTR_W-1:0] instr;
    logic [FQ_PC_W-1:0]    pcplus8;
  } fq_entry_t;
endpackage

// File: rtl/fq_ptr.sv
// Wrapping queue pointer: advances on inc, returns to 0 on clr, wraps DEPTH-1 -> 0.
module fq_ptr #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc,
  input  logic          clr,
  output logic [PW-1:0] ptr
);

  // Explicit wrap so non-power-of-two depths never index past the last entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry FIFO of {instruction, PC+8} between fetch and decode, with stall-held head
// and a branch flush that empties it in one cycle.
module fetch_decode_queue #(
  parameter int INSTR_W = fetch_pkg::FQ_INSTR_W,
  parameter int PC_W    = fetch_pkg::FQ_PC_W,
  parameter int DEPTH   = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] instr_f,
  input  logic [PC_W-1:0]    pcplus8_f,
  input  logic               valid_f,
  output logic               ready_f,
  input  logic               stall_d,
  input  logic               flush_d,
  output logic [INSTR_W-1:0] instr_d,
  output logic [PC_W-1:0]    pcplus8_d,
  output logic               valid_d,
  output logic [CW-1:0]      count
);
  import fetch_pkg::*;

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  fq_entry_t     mem [DEPTH];
  fq_entry_t     head;

  assign ready_f = (count < CW'(DEPTH)) & ~flush_d;
  assign push    = valid_f & ready_f;
  assign pop     = valid_d & ~stall_d & ~flush_d;

  fq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (pop),
    .clr     (flush_d),
    .ptr     (rd_ptr)
  );

  fq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (push),
    .clr     (flush_d),
    .ptr     (wr_ptr)
  );

  // Storage is deliberately never cleared; count alone decides what is live
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{instr: instr_f, pcplus8: pcplus8_f};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (flush_d) begin
      count <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head      = mem[rd_ptr];
  assign valid_d   = (count != '0);
  assign instr_d   = valid_d ? head.instr : NOP_INSTR;
  assign pcplus8_d = valid_d ? head.pcplus8 : '0;

  // Fetch must honour ready_f; a push offered while full is dropped
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(valid_f && !ready_f && !flush_d))
        else $warning("fetch_decode_queue: push offered while full was dropped");
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Drives DEPTH=4 and DEPTH=3 queues with identical stimulus and checks both against queue models.
module tb_fetch_decode_queue;
  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_f;
  logic [31:0] pcplus8_f;
  logic        valid_f;
  logic        stall_d;
  logic        flush_d;

  logic        ready4, valid4, ready3, valid3;
  logic [31:0] instr4, pc4, instr3, pc3;
  logic [2:0]  count4;
  logic [1:0]  count3;

  int total  = 0;
  int passed = 0;

  logic [63:0] q4[$];
  logic [63:0] q3[$];

  always #5 clk = ~clk;

  fetch_decode_queue #(.DEPTH(4)) u_d4 (
    .clk(clk), .reset_n(reset_n), .instr_f(instr_f), .pcplus8_f(pcplus8_f),
    .valid_f(valid_f), .ready_f(ready4), .stall_d(stall_d), .flush_d(flush_d),
    .instr_d(instr4), .pcplus8_d(pc4), .valid_d(valid4), .count(count4)
  );

  fetch_decode_queue #(.DEPTH(3)) u_d3 (
    .clk(clk), .reset_n(reset_n), .instr_f(instr_f), .pcplus8_f(pcplus8_f),
    .valid_f(valid_f), .ready_f(ready3), .stall_d(stall_d), .flush_d(flush_d),
    .instr_d(instr3), .pcplus8_d(pc3), .valid_d(valid3), .count(count3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [63:0] h4;
    logic [63:0] h3;
    h4 = (q4.size() > 0) ? q4[0] : {NOP, 32'h0};
    h3 = (q3.size() > 0) ? q3[0] : {NOP, 32'h0};
    chk({tag, " d4.valid_d"},   64'(valid4), 64'(q4.size() > 0));
    chk({tag, " d4.instr_d"},   64'(instr4), 64'(h4[63:32]));
    chk({tag, " d4.pcplus8_d"}, 64'(pc4),    64'(h4[31:0]));
    chk({tag, " d4.count"},     64'(count4), 64'(q4.size()));
    chk({tag, " d4.ready_f"},   64'(ready4), 64'((q4.size() < 4) && !flush_d));
    chk({tag, " d3.valid_d"},   64'(valid3), 64'(q3.size() > 0));
    chk({tag, " d3.instr_d"},   64'(instr3), 64'(h3[63:32]));
    chk({tag, " d3.pcplus8_d"}, 64'(pc3),    64'(h3[31:0]));
    chk({tag, " d3.count"},     64'(count3), 64'(q3.size()));
    chk({tag, " d3.ready_f"},   64'(ready3), 64'((q3.size() < 3) && !flush_d));
  endtask

  // Reference: flush empties; otherwise pop the head if not stalled, append if there was room
  task automatic model_edge(input logic v, input logic [63:0] e, input logic st, input logic fl);
    logic a4, a3, p4, p3;
    a4 = v && (q4.size() < 4);
    a3 = v && (q3.size() < 3);
    p4 = (q4.size() > 0) && !st;
    p3 = (q3.size() > 0) && !st;
    if (fl) begin
      q4.delete();
      q3.delete();
    end else begin
      if (p4) void'(q4.pop_front());
      if (a4) q4.push_back(e);
      if (p3) void'(q3.pop_front());
      if (a3) q3.push_back(e);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic st, input logic fl, input string tag);
    valid_f = v; instr_f = ins; pcplus8_f = pc; stall_d = st; flush_d = fl;
    #1 check_all(tag);
    @(posedge clk);
    model_edge(v, {ins, pc}, st, fl);
    #1;
  endtask

  initial begin
    logic v, st, fl;
    reset_n = 1'b0; valid_f = 1'b0; instr_f = '0; pcplus8_f = '0; stall_d = 1'b0; flush_d = 1'b0;
    #2 check_all("t1 in reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "t1 idle");

    cyc(1'b1, 32'hE3A01005, 32'h08, 1'b0, 1'b0, "t2 push A");
    cyc(1'b1, 32'hE0812002, 32'h0C, 1'b0, 1'b0, "t2 push B, A at head");
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "t2 B at head");
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "t2 empty");

    for (int i = 0; i < 5; i++) cyc(1'b1, $urandom, $urandom, 1'b1, 1'b0, "t3 stalled push");
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t3 full hold");
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "t3 drain");

    for (int i = 0; i < 2; i++) cyc(1'b1, $urandom, $urandom, 1'b1, 1'b0, "t4 fill");
    for (int i = 0; i < 10; i++) cyc(1'b1, $urandom, $urandom, 1'b0, 1'b0, "t4 push+pop");
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "t4 drain");

    for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, $urandom, 1'b1, 1'b0, "t5 fill");
    cyc(1'b1, $urandom, $urandom, 1'b0, 1'b1, "t5 flush with push");
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "t5 after flush");

    for (int i = 0; i < 2; i++) cyc(1'b1, $urandom, $urandom, 1'b1, 1'b0, "t6 fill");
    valid_f = 1'b0;
    reset_n = 1'b0;
    q4.delete();
    q3.delete();
    #1 check_all("t6 async reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(1'b1, 32'h12345678, 32'h40, 1'b0, 1'b0, "t6 first push");
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "t6 head");
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "t6 empty");

    for (int i = 0; i < 300; i++) begin
      v  = (($urandom % 4) != 0) && (q3.size() < 3);
      st = (($urandom % 3) == 0);
      fl = (($urandom % 16) == 0);
      cyc(v, $urandom, $urandom, st, fl, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
